// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI shift engine: mode bit positions,
// frame state encoding and the default word width.
package spi_pkg;

  localparam int unsigned MODE_CPOL_BIT = 1;
  localparam int unsigned MODE_CPHA_BIT = 0;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_shift_engine_if.sv
// Signal bundle between the SPI shift engine, the synchronized SPI pins
// and the downstream register-access logic.
interface spi_shift_engine_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 4
);

  logic [1:0]       mode;
  logic             spi_cs_n;
  logic             spi_clk;
  logic             spi_mosi;
  logic             spi_miso;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic [IDXW-1:0]  byte_idx;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             frame_start;
  logic             frame_end;

  // Engine side
  modport slave (
    input  mode, spi_cs_n, spi_clk, spi_mosi, tx_data,
    output spi_miso, rx_data, rx_valid, byte_idx, tx_load, frame_start, frame_end
  );

  // Environment side (pins and register logic)
  modport master (
    output mode, spi_cs_n, spi_clk, spi_mosi, tx_data,
    input  spi_miso, rx_data, rx_valid, byte_idx, tx_load, frame_start, frame_end
  );

endinterface

// File: rtl/spi_shift_engine_edge_detect.sv
// Oversampled SPI clock edge detector. Classifies each spi_clk transition
// as the sample or shift edge for the given CPOL/CPHA.
module spi_edge_detect (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic spi_clk,
  input  logic cpol,
  input  logic cpha,
  output logic sample_edge,
  output logic shift_edge
);

  logic sclk_q;
  logic sclk_d;
  logic toggled;
  logic leading;
  logic trailing;

  // Leading edge leaves the idle (CPOL) level, trailing edge returns to it
  always_comb begin
    sclk_d      = spi_clk;
    toggled     = (spi_clk != sclk_q);
    leading     = toggled && (sclk_q == cpol);
    trailing    = toggled && (sclk_q != cpol);
    sample_edge = ena && (cpha ? trailing : leading);
    shift_edge  = ena && (cpha ? leading : trailing);
  end

  // Previous spi_clk level, tracked even while CS is high
  always_ff @(posedge clk) begin
    if (!rstb) begin
      sclk_q <= 1'b0;
    end else if (ena) begin
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI target bit engine: deserializes MOSI into words with a valid pulse
// and serializes downstream words onto MISO, all four SPI modes.
// Build option: define SPI_LSB_FIRST_EN for LSB-first words on both lines.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned IDXW  = 4
) (
  input logic              clk,
  input logic              rstb,
  input logic              ena,
  spi_shift_engine_if.slave bus
);

  localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);
`ifdef SPI_LSB_FIRST_EN
  localparam int unsigned OUT_BIT = 0;
`else
  localparam int unsigned OUT_BIT = WIDTH - 1;
`endif

  spi_state_t       state_q, state_d;
  logic             cs_n_q, cs_n_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNTW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [IDXW-1:0]  word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [IDXW-1:0]  byte_idx_q, byte_idx_d;
  logic             tx_load_q, tx_load_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             miso_q, miso_d;

  logic             sample_edge;
  logic             shift_edge;
  logic [WIDTH-1:0] rx_word;
  logic [WIDTH-1:0] tx_shifted;

  spi_edge_detect u_edge (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .spi_clk     (bus.spi_clk),
    .cpol        (mode_q[MODE_CPOL_BIT]),
    .cpha        (mode_q[MODE_CPHA_BIT]),
    .sample_edge (sample_edge),
    .shift_edge  (shift_edge)
  );

  // Frame control, receive/transmit shifting and output pulse generation
  always_comb begin
`ifdef SPI_LSB_FIRST_EN
    rx_word    = {bus.spi_mosi, rx_sr_q[WIDTH-1:1]};
    tx_shifted = tx_sr_q >> 1;
`else
    rx_word    = {rx_sr_q[WIDTH-2:0], bus.spi_mosi};
    tx_shifted = tx_sr_q << 1;
`endif
    state_d       = state_q;
    cs_n_d        = bus.spi_cs_n;
    mode_d        = mode_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    word_cnt_d    = word_cnt_q;
    rx_data_d     = rx_data_q;
    byte_idx_d    = byte_idx_q;
    rx_valid_d    = 1'b0;
    tx_load_d     = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;

    case (state_q)
      SPI_IDLE: begin
        // A frame needs a genuine high-to-low CS transition; edges in this
        // cycle are ignored because the engine is still idle.
        if (cs_n_q && !bus.spi_cs_n) begin
          state_d       = SPI_ACTIVE;
          frame_start_d = 1'b1;
          mode_d        = bus.mode;
          bit_cnt_d     = '0;
          rx_sr_d       = '0;
          word_cnt_d    = '0;
          byte_idx_d    = '0;
          if (!bus.mode[MODE_CPHA_BIT]) begin
            tx_sr_d   = bus.tx_data;
            tx_load_d = 1'b1;
          end
        end
      end
      SPI_ACTIVE: begin
        if (bus.spi_cs_n) begin
          state_d     = SPI_IDLE;
          frame_end_d = 1'b1;
          bit_cnt_d   = '0;
          rx_sr_d     = '0;
        end else if (sample_edge) begin
          rx_sr_d = rx_word;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            byte_idx_d = word_cnt_q;
            if (word_cnt_q != '1) begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (shift_edge) begin
          if (bit_cnt_q == '0) begin
            tx_sr_d   = bus.tx_data;
            tx_load_d = 1'b1;
          end else begin
            tx_sr_d = tx_shifted;
          end
        end
      end
      default: state_d = SPI_IDLE;
    endcase

    // MISO is registered from next-state values so it tracks tx_sr without lag
    miso_d = (state_d == SPI_ACTIVE) ? tx_sr_d[OUT_BIT] : 1'b0;
  end

  // State and output registers; all hold while ena is low.
  // cs_n_q resets to 0 so a frame abandoned by reset is not resumed.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q       <= SPI_IDLE;
      cs_n_q        <= 1'b0;
      mode_q        <= '0;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      word_cnt_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      byte_idx_q    <= '0;
      tx_load_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      miso_q        <= 1'b0;
    end else if (ena) begin
      state_q       <= state_d;
      cs_n_q        <= cs_n_d;
      mode_q        <= mode_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      word_cnt_q    <= word_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      byte_idx_q    <= byte_idx_d;
      tx_load_q     <= tx_load_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      miso_q        <= miso_d;
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.byte_idx    = byte_idx_q;
  assign bus.tx_load     = tx_load_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed self-checking bench for spi_shift_engine; acts as SPI host and
// register-side data source. Honours SPI_LSB_FIRST_EN for wire bit order.
module tb_spi_shift_engine;

  localparam int H = 6;  // SPI half period in clk cycles

  logic clk;
  logic rstb;
  logic ena;

  spi_shift_engine_if #(.WIDTH(8), .IDXW(4)) bus ();

  spi_shift_engine #(.WIDTH(8), .IDXW(4)) dut (
    .clk  (clk),
    .rstb (rstb),
    .ena  (ena),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Event logs, written only by the monitor
  logic [7:0] rx_log  [64];
  logic [3:0] idx_log [64];
  int rx_n = 0;
  int tl_n = 0;
  int fs_n = 0;
  int fe_n = 0;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_log[rx_n % 64]  = bus.rx_data;
      idx_log[rx_n % 64] = bus.byte_idx;
      rx_n++;
    end
    if (bus.tx_load)     tl_n++;
    if (bus.frame_start) fs_n++;
    if (bus.frame_end)   fe_n++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wire_pos(input int bi);
`ifdef SPI_LSB_FIRST_EN
    return bi;
`else
    return 7 - bi;
`endif
  endfunction

  int tl_setup;

  // Host-side frame: nbits on MOSI from w0 then w1, MISO collected into m0/m1.
  // tx_data starts at t0 and switches to t1 3 clk after each word's last sample.
  task automatic run_frame(input logic [1:0] pm, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] t0, input logic [7:0] t1, input int nbits,
                           input bit keep_cs, input bit toggle_mode,
                           output logic [7:0] m0, output logic [7:0] m1, output logic last_miso);
    logic cpol, cpha, b, sb;
    logic [7:0] cur;
    int bi, pos;
    cpol = pm[1];
    cpha = pm[0];
    m0 = '0;
    m1 = '0;
    last_miso = 1'b0;
    bus.mode    = pm;
    bus.spi_clk = cpol;
    bus.tx_data = t0;
    repeat (H) @(negedge clk);
    bus.spi_cs_n = 1'b0;
    repeat (H) @(negedge clk);
    tl_setup = tl_n;
    if (toggle_mode) bus.mode = ~pm;
    for (int i = 0; i < nbits; i++) begin
      cur = (i < 8) ? w0 : w1;
      bi  = i % 8;
      pos = wire_pos(bi);
      b   = cur[pos];
      if (!cpha) begin
        bus.spi_mosi = b;
        repeat (H) @(negedge clk);
        sb = bus.spi_miso;
        bus.spi_clk = ~cpol;
        if (bi == 7) begin
          repeat (3) @(negedge clk);
          bus.tx_data = t1;
          repeat (H - 3) @(negedge clk);
        end else begin
          repeat (H) @(negedge clk);
        end
        bus.spi_clk = cpol;
      end else begin
        repeat (H) @(negedge clk);
        bus.spi_clk  = ~cpol;
        bus.spi_mosi = b;
        repeat (H) @(negedge clk);
        sb = bus.spi_miso;
        bus.spi_clk = cpol;
        if (bi == 7) begin
          repeat (3) @(negedge clk);
          bus.tx_data = t1;
        end
      end
      if (i < 8) m0[pos] = sb;
      else       m1[pos] = sb;
      last_miso = sb;
    end
    repeat (H) @(negedge clk);
    if (!keep_cs) begin
      bus.spi_cs_n = 1'b1;
      repeat (H) @(negedge clk);
    end
  endtask

  logic [7:0] m0, m1;
  logic lm;
  int rb, tb0, fsb, feb;

  initial begin
    rstb = 1'b0;
    ena  = 1'b1;
    bus.mode     = 2'b00;
    bus.spi_cs_n = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_byte_idx", bus.byte_idx, 4'h0);
    chk("rst_miso", bus.spi_miso, 1'b0);
    chk("rst_tx_load", bus.tx_load, 1'b0);
    chk("rst_frame_start", bus.frame_start, 1'b0);
    chk("rst_frame_end", bus.frame_end, 1'b0);
    rstb = 1'b1;
    repeat (4) @(negedge clk);

    // Mode 0 single word
    rb = rx_n; tb0 = tl_n; fsb = fs_n; feb = fe_n;
    run_frame(2'b00, 8'hA5, 8'h00, 8'h3C, 8'h00, 8, 1'b0, 1'b0, m0, m1, lm);
    chk("m0_rx_count", rx_n - rb, 1);
    chk("m0_rx_data", rx_log[rb % 64], 8'hA5);
    chk("m0_byte_idx", idx_log[rb % 64], 4'h0);
    chk("m0_miso", m0, 8'h3C);
    chk("m0_tx_load_at_cs", tl_setup - tb0, 1);
    chk("m0_tx_load_total", tl_n - tb0, 2);
    chk("m0_frame_start", fs_n - fsb, 1);
    chk("m0_frame_end", fe_n - feb, 1);

    // Modes 1..3, two-word frames
    for (int m = 1; m < 4; m++) begin
      rb = rx_n; fsb = fs_n; feb = fe_n;
      run_frame(m[1:0], 8'h81, 8'h7E, 8'hF0, 8'h0F, 16, 1'b0, 1'b0, m0, m1, lm);
      chk($sformatf("m%0d_rx_count", m), rx_n - rb, 2);
      chk($sformatf("m%0d_rx_w0", m), rx_log[rb % 64], 8'h81);
      chk($sformatf("m%0d_rx_w1", m), rx_log[(rb + 1) % 64], 8'h7E);
      chk($sformatf("m%0d_idx0", m), idx_log[rb % 64], 4'h0);
      chk($sformatf("m%0d_idx1", m), idx_log[(rb + 1) % 64], 4'h1);
      chk($sformatf("m%0d_miso_w0", m), m0, 8'hF0);
      chk($sformatf("m%0d_miso_w1", m), m1, 8'h0F);
      chk($sformatf("m%0d_frames", m), (fs_n - fsb) * 16 + (fe_n - feb), 17);
    end

    // Aborted word, then a clean frame
    rb = rx_n; feb = fe_n;
    run_frame(2'b00, 8'hFF, 8'h00, 8'h00, 8'h00, 5, 1'b0, 1'b0, m0, m1, lm);
    chk("abort_no_rx", rx_n - rb, 0);
    chk("abort_frame_end", fe_n - feb, 1);
    rb = rx_n;
    run_frame(2'b00, 8'h55, 8'h00, 8'h99, 8'h00, 8, 1'b0, 1'b0, m0, m1, lm);
    chk("after_abort_count", rx_n - rb, 1);
    chk("after_abort_data", rx_log[rb % 64], 8'h55);
    chk("after_abort_idx", idx_log[rb % 64], 4'h0);
    chk("after_abort_miso", m0, 8'h99);

    // Mode changed mid-frame: latched mode 3 must be used
    rb = rx_n;
    run_frame(2'b11, 8'h81, 8'h00, 8'h5A, 8'h00, 8, 1'b0, 1'b1, m0, m1, lm);
    chk("mtoggle_count", rx_n - rb, 1);
    chk("mtoggle_data", rx_log[rb % 64], 8'h81);
    chk("mtoggle_miso", m0, 8'h5A);

    // Two-word mode 3 frame leaves byte_idx=1, then reset mid-word
    run_frame(2'b11, 8'h12, 8'h34, 8'h00, 8'h00, 16, 1'b0, 1'b0, m0, m1, lm);
    chk("pre_rst_idx", bus.byte_idx, 4'h1);
    run_frame(2'b00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 3, 1'b1, 1'b0, m0, m1, lm);
    chk("pre_rst_miso", bus.spi_miso, 1'b1);
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_rx_data", bus.rx_data, 8'h00);
    chk("mid_rst_byte_idx", bus.byte_idx, 4'h0);
    chk("mid_rst_miso", bus.spi_miso, 1'b0);
    chk("mid_rst_valid_load", {bus.rx_valid, bus.tx_load, bus.frame_start, bus.frame_end}, 4'h0);
    rstb = 1'b1;
    rb = rx_n; fsb = fs_n;
    for (int k = 0; k < 2; k++) begin
      repeat (H) @(negedge clk);
      bus.spi_clk = 1'b1;
      repeat (H) @(negedge clk);
      bus.spi_clk = 1'b0;
    end
    repeat (H) @(negedge clk);
    chk("post_rst_no_resume", (fs_n - fsb) * 16 + (rx_n - rb), 0);
    chk("post_rst_miso", bus.spi_miso, 1'b0);
    bus.spi_cs_n = 1'b1;
    repeat (H) @(negedge clk);
    rb = rx_n;
    run_frame(2'b00, 8'hC3, 8'h00, 8'h6E, 8'h00, 8, 1'b0, 1'b0, m0, m1, lm);
    chk("post_rst_count", rx_n - rb, 1);
    chk("post_rst_data", rx_log[rb % 64], 8'hC3);
    chk("post_rst_miso_word", m0, 8'h6E);

`ifdef SPI_LSB_FIRST_EN
    rb = rx_n;
    run_frame(2'b00, 8'h01, 8'h00, 8'h80, 8'h00, 8, 1'b0, 1'b0, m0, m1, lm);
    chk("lsb_rx_data", rx_log[rb % 64], 8'h01);
    chk("lsb_miso_word", m0, 8'h80);
    chk("lsb_miso_last_bit", lm, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
